iq_demod: RTL and testbench

//  Quadrature integrate-and-dump demodulator, directly downstream of the DDS.

---
 rtl/iq_demod_pkg.sv | 29 ++
 rtl/iq_mac_lane.sv | 47 ++++
 rtl/iq_demod.sv | 100 ++++++++++
 tb/tb_iq_demod.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_demod_pkg.sv
// iq_demod_pkg: shared widths, lane control bundle and offset-binary helpers for iq_demod.
package iq_demod_pkg;

    localparam int ADC_W_DEF  = 12;
    localparam int DDS_W_DEF  = 14;
    localparam int LOG2_N_DEF = 14;
    localparam int ACC_W_DEF  = 48;
    localparam int ALIGN_DEF  = 1;

    typedef struct packed {
        logic ld1;
        logic ld2;
        logic acc_en;
        logic dump;
        logic clear;
    } lane_ctl_t;

    function automatic int acc_w_min(input int adc_w, input int dds_w, input int log2_n);
        return adc_w + dds_w + log2_n;
    endfunction

    // Flip the MSB, then sign-extend from bit w-1 by a left/arith-right shift pair.
    function automatic logic signed [31:0] ob2s(input logic [31:0] v, input int w);
        logic [31:0] x;
        x = (v ^ (32'd1 << (w - 1))) << (32 - w);
        return $signed(x) >>> (32 - w);
    endfunction

endpackage

// File: rtl/iq_mac_lane.sv
// iq_mac_lane: one mixer channel - operand registers, product register, integrate-and-dump.
module iq_mac_lane
    import iq_demod_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int DDS_W = DDS_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  lane_ctl_t               ctl,
    input  logic [ADC_W-1:0]        adc,
    input  logic [DDS_W-1:0]        dds,
    output logic signed [ACC_W-1:0] sum
);

    localparam int PW = ADC_W + DDS_W;

    logic signed [ADC_W-1:0] a;
    logic signed [DDS_W-1:0] b;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] nxt;

    assign nxt = acc + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            b    <= '0;
            prod <= '0;
            acc  <= '0;
            sum  <= '0;
        end else begin
            if (ctl.ld1) begin
                a <= ADC_W'(ob2s(32'(adc), ADC_W));
                b <= DDS_W'(ob2s(32'(dds), DDS_W));
            end
            if (ctl.ld2) prod <= PW'(a) * PW'(b);
            // The dumping sample lands in sum, so the next frame starts from zero.
            if (ctl.clear) acc <= '0;
            else if (ctl.acc_en) acc <= ctl.dump ? '0 : nxt;
            if (ctl.dump) sum <= nxt;
        end
    end

endmodule

// File: rtl/iq_demod.sv
// iq_demod: quadrature integrate-and-dump demodulator mixing ADC samples with DDS sin/cos.
module iq_demod
    import iq_demod_pkg::*;
#(
    parameter int ADC_W  = ADC_W_DEF,
    parameter int DDS_W  = DDS_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ALIGN  = ALIGN_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADC_W-1:0]        adc_data,
    input  logic                    sample_en,
    input  logic [DDS_W-1:0]        sin_i,
    input  logic [DDS_W-1:0]        cos_i,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] i_out,
    output logic signed [ACC_W-1:0] q_out,
    output logic                    iq_valid,
    output logic [LOG2_N-1:0]       frame_cnt
);

    generate
        if (ACC_W < acc_w_min(ADC_W, DDS_W, LOG2_N)) begin : g_acc_w_bad
            $error("iq_demod: ACC_W must be >= ADC_W+DDS_W+LOG2_N");
        end
    endgenerate

    logic [ADC_W-1:0] adc_a;
    logic             en_a;
    logic             v1;
    logic             v2;
    logic             dump;
    lane_ctl_t        ctl;

    // Delay the ADC side so each sample meets the DDS value read out on its cycle.
    generate
        if (ALIGN == 0) begin : g_no_align
            assign adc_a = adc_data;
            assign en_a  = sample_en;
        end else begin : g_align
            logic [ADC_W-1:0] adc_d [ALIGN];
            logic             en_d  [ALIGN];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < ALIGN; k++) begin
                        adc_d[k] <= '0;
                        en_d[k]  <= 1'b0;
                    end
                end else begin
                    adc_d[0] <= adc_data;
                    en_d[0]  <= sample_en & ~clear;
                    for (int k = 1; k < ALIGN; k++) begin
                        adc_d[k] <= adc_d[k-1];
                        en_d[k]  <= en_d[k-1] & ~clear;
                    end
                end
            end
            assign adc_a = adc_d[ALIGN-1];
            assign en_a  = en_d[ALIGN-1];
        end
    endgenerate

    assign dump = v2 && (frame_cnt == {LOG2_N{1'b1}}) && !clear;
    assign ctl  = '{ld1: en_a, ld2: v1, acc_en: v2, dump: dump, clear: clear};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            frame_cnt <= '0;
            iq_valid  <= 1'b0;
        end else begin
            v1        <= en_a & ~clear;
            v2        <= v1 & ~clear;
            frame_cnt <= clear ? '0 : v2 ? frame_cnt + LOG2_N'(1) : frame_cnt;
            iq_valid  <= dump;
        end
    end

    iq_mac_lane #(.ADC_W(ADC_W), .DDS_W(DDS_W), .ACC_W(ACC_W)) u_lane_i (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl),
        .adc   (adc_a),
        .dds   (cos_i),
        .sum   (i_out)
    );

    iq_mac_lane #(.ADC_W(ADC_W), .DDS_W(DDS_W), .ACC_W(ACC_W)) u_lane_q (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl),
        .adc   (adc_a),
        .dds   (sin_i),
        .sum   (q_out)
    );

endmodule

// File: tb/tb_iq_demod.sv
// tb_iq_demod: table vectors, corner sequences and a random reference model for iq_demod.
module tb_iq_demod;

    localparam int ALIGN  = 1;
    localparam int LOG2_N = 2;
    localparam int FR     = 4;
    localparam int NFRM   = 1000;

    logic               clk;
    logic               rst_n;
    logic [11:0]        adc_data;
    logic               sample_en;
    logic [13:0]        sin_i;
    logic [13:0]        cos_i;
    logic               clear;
    logic signed [47:0] i_out;
    logic signed [47:0] q_out;
    logic               iq_valid;
    logic [1:0]         frame_cnt;

    iq_demod #(.ADC_W(12), .DDS_W(14), .LOG2_N(LOG2_N), .ACC_W(48), .ALIGN(ALIGN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .sample_en (sample_en),
        .sin_i     (sin_i),
        .cos_i     (cos_i),
        .clear     (clear),
        .i_out     (i_out),
        .q_out     (q_out),
        .iq_valid  (iq_valid),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                 cyc = 0;
    logic signed [47:0] got_i[$];
    logic signed [47:0] got_q[$];
    int                 got_c[$];
    int                 got_fc[$];

    always @(negedge clk) begin
        cyc++;
        if (iq_valid === 1'b1) begin
            got_i.push_back(i_out);
            got_q.push_back(q_out);
            got_c.push_back(cyc);
            got_fc.push_back(int'(frame_cnt));
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [11:0] a, input logic [13:0] s, input logic [13:0] c);
        adc_data  = a;
        sin_i     = s;
        cos_i     = c;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic send(input logic [11:0] a, input logic [13:0] s, input logic [13:0] c,
                        input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            put(a, s, c);
            repeat (gap) tick();
        end
    endtask

    // Edges counted from the one that samples the last sample_en (inclusive) to the strobe.
    task automatic frame_lat(input logic [11:0] a, input logic [13:0] s, input logic [13:0] c,
                             input int gap, output int lat);
        send(a, s, c, FR - 1, gap);
        adc_data  = a;
        sin_i     = s;
        cos_i     = c;
        sample_en = 1'b1;
        lat = 0;
        do begin
            tick();
            sample_en = 1'b0;
            lat++;
        end while (iq_valid !== 1'b1 && lat < 20);
    endtask

    function automatic longint sv(input int v, input int w);
        return longint'(v) - (longint'(1) << (w - 1));
    endfunction

    typedef struct {
        logic [11:0] adc;
        logic [13:0] s;
        logic [13:0] c;
        int          gap;
        longint      ei;
        longint      eq;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int     lat, n0, fc_bad, used, sent;
        longint prev_i, ai, aq;
        longint exp_i[$], exp_q[$];
        logic [11:0] dq_a[$];
        bit          dq_e[$];

        tbl[0] = '{12'hFFF, 14'h3FFF, 14'h2000, 0,         0,  67067908};
        tbl[1] = '{12'h000, 14'h0000, 14'h0000, 2,  67108864,  67108864};
        tbl[2] = '{12'h800, 14'h3FFF, 14'h0000, 1,         0,         0};
        tbl[3] = '{12'hFFF, 14'h0000, 14'h0000, 0, -67076096, -67076096};
        tbl[4] = '{12'h000, 14'h2000, 14'h3FFF, 4, -67100672,         0};

        rst_n = 1'b0; clear = 1'b0; sample_en = 1'b0;
        adc_data = '0; sin_i = '0; cos_i = '0;
        repeat (3) tick();
        chk("reset_i", i_out, 0);
        chk("reset_q", q_out, 0);
        chk("reset_valid", longint'(iq_valid), 0);
        chk("reset_fcnt", longint'(frame_cnt), 0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[v]) begin
            n0 = got_i.size();
            frame_lat(tbl[v].adc, tbl[v].s, tbl[v].c, tbl[v].gap, lat);
            repeat (3) tick();
            chk($sformatf("vec%0d_latency", v), lat, ALIGN + 3);
            chk($sformatf("vec%0d_pulses", v), got_i.size() - n0, 1);
            chk($sformatf("vec%0d_i", v), i_out, tbl[v].ei);
            chk($sformatf("vec%0d_q", v), q_out, tbl[v].eq);
            if (got_i.size() > n0) chk($sformatf("vec%0d_fcnt_at_dump", v), got_fc[n0], 0);
        end

        n0 = got_i.size();
        send(12'hFFF, 14'h2000, 14'h3FFF, 12, 0);
        repeat (8) tick();
        chk("cont_pulses", got_i.size() - n0, 3);
        if (got_i.size() >= n0 + 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cont_i%0d", k), got_i[n0+k], 67067908);
                chk($sformatf("cont_q%0d", k), got_q[n0+k], 0);
                if (k > 0) chk($sformatf("cont_gap%0d", k), got_c[n0+k] - got_c[n0+k-1], FR);
            end
        end

        n0 = got_i.size();
        send(12'hFFF, 14'h3FFF, 14'h3FFF, 2, 0);
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(12'h000, 14'h0000, 14'h0000, 4, 1);
        repeat (8) tick();
        chk("clear_pulses", got_i.size() - n0, 1);
        chk("clear_i", i_out, 67108864);
        chk("clear_q", q_out, 67108864);

        prev_i = i_out;
        n0 = got_i.size();
        send(12'hFFF, 14'h3FFF, 14'h3FFF, 4, 0);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        chk("cldump_pulses", got_i.size() - n0, 0);
        chk("cldump_i_hold", i_out, prev_i);
        chk("cldump_fcnt", longint'(frame_cnt), 0);
        send(12'hFFF, 14'h0000, 14'h0000, 4, 0);
        repeat (8) tick();
        chk("cldump_next_pulses", got_i.size() - n0, 1);
        chk("cldump_next_i", i_out, -67076096);

        send(12'hFFF, 14'h3FFF, 14'h3FFF, 2, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_i", i_out, 0);
        chk("arst_q", q_out, 0);
        chk("arst_valid", longint'(iq_valid), 0);
        chk("arst_fcnt", longint'(frame_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        n0 = got_i.size();
        send(12'h000, 14'h0000, 14'h0000, 3, 0);
        repeat (8) tick();
        chk("arst_early_pulses", got_i.size() - n0, 0);
        chk("arst_fcnt3", longint'(frame_cnt), 3);
        send(12'h000, 14'h0000, 14'h0000, 1, 0);
        repeat (6) tick();
        chk("arst_pulses", got_i.size() - n0, 1);
        chk("arst_dump_i", i_out, 67108864);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        n0 = got_i.size();
        for (int k = 0; k < ALIGN; k++) begin
            dq_a.push_back('0);
            dq_e.push_back(1'b0);
        end
        used = 0; sent = 0; ai = 0; aq = 0;
        while (used < NFRM * FR + 2) begin
            logic [11:0] a, da;
            logic [13:0] s, c;
            bit          e, de;
            a = 12'($urandom);
            s = 14'($urandom);
            c = 14'($urandom);
            e = (sent < NFRM * FR + 2) && ($urandom_range(2, 0) != 0);
            adc_data = a; sin_i = s; cos_i = c; sample_en = e;
            dq_a.push_back(a);
            dq_e.push_back(e);
            da = dq_a.pop_front();
            de = dq_e.pop_front();
            if (de) begin
                ai += sv(int'(da), 12) * sv(int'(c), 14);
                aq += sv(int'(da), 12) * sv(int'(s), 14);
                used++;
                if (used % FR == 0) begin
                    exp_i.push_back(ai);
                    exp_q.push_back(aq);
                    ai = 0;
                    aq = 0;
                end
            end
            if (e) sent++;
            tick();
        end
        sample_en = 1'b0;
        repeat (10) tick();
        chk("rand_frames", got_i.size() - n0, NFRM);
        fc_bad = 0;
        for (int f = 0; f < NFRM; f++) begin
            if (n0 + f < got_i.size()) begin
                chk($sformatf("rand_i%0d", f), got_i[n0+f], exp_i[f]);
                chk($sformatf("rand_q%0d", f), got_q[n0+f], exp_q[f]);
                if (got_fc[n0+f] != 0) fc_bad++;
            end
        end
        chk("rand_fcnt_wrap_at_dump", fc_bad, 0);
        chk("rand_fcnt_tail", longint'(frame_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
